// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seven_seg_pkg -- shared glyph table and hex-to-segment helper
// Revision : 1.0  initial release
// ============================================================================
package seven_seg_pkg;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex2seg(input logic [3:0] nibble);
    return GLYPH[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_glyph.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_glyph -- nibble to seven-segment pattern, selectable polarity
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_glyph
  import seven_seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  logic [6:0] w_pattern;

  always_comb begin
    w_pattern = hex2seg(nibble);
    seg       = ACTIVE_LOW ? ~w_pattern : w_pattern;
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan -- multiplexed N-digit seven-segment driver
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int c_presc_w = $clog2(CLK_DIV);
  localparam int c_idx_w   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_presc_w-1:0]  c_presc_max = c_presc_w'(CLK_DIV - 1);
  localparam logic [c_idx_w-1:0]    c_idx_max   = c_idx_w'(NUM_DIGITS - 1);
  localparam logic [6:0]            c_seg_off   = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic                  c_dp_off    = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] c_an_off    = DIG_ACTIVE_LOW ? '1 : '0;

  logic [c_presc_w-1:0]    r_presc;
  logic [c_idx_w-1:0]      r_idx;

  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic [NUM_DIGITS-1:0]   r_pend_blank;
  logic                    r_pend_v;

  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [NUM_DIGITS-1:0]   r_act_blank;

  logic [6:0]              r_seg;
  logic                    r_seg_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_tick;
  logic                    w_frame_end;
  logic [NUM_DIGITS-1:0]   w_lz_mask;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_glyph;

  assign w_tick      = (r_presc == c_presc_max);
  assign w_frame_end = w_tick && (r_idx == c_idx_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the pending stage so
  // the next frame already shows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_val   <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_v     <= 1'b0;
      r_act_val    <= '0;
      r_act_dp     <= '0;
      r_act_blank  <= '0;
    end else begin
      if (load) begin
        r_pend_val   <= value;
        r_pend_dp    <= dp;
        r_pend_blank <= blank;
      end
      if (w_frame_end) begin
        r_pend_v <= 1'b0;
        if (load) begin
          r_act_val   <= value;
          r_act_dp    <= dp;
          r_act_blank <= blank;
        end else if (r_pend_v) begin
          r_act_val   <= r_pend_val;
          r_act_dp    <= r_pend_dp;
          r_act_blank <= r_pend_blank;
        end
      end else if (load) begin
        r_pend_v <= 1'b1;
      end
    end
  end

  if (LZ_BLANK) begin : g_lz
    logic w_zero_run;

    // Walk down from the most significant digit; a digit is a leading zero
    // while every nibble at or above it is zero. Digit 0 always shows.
    always_comb begin
      w_lz_mask  = '0;
      w_zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        w_zero_run   = w_zero_run & (r_act_val[4*i +: 4] == 4'h0);
        w_lz_mask[i] = w_zero_run;
      end
    end
  end else begin : g_no_lz
    assign w_lz_mask = '0;
  end

  always_comb begin
    w_nib    = 4'h0;
    w_dp_sel = 1'b0;
    w_dark   = 1'b0;
    w_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_idx_w'(i)) begin
        w_nib       = r_act_val[4*i +: 4];
        w_dp_sel    = r_act_dp[i];
        w_dark      = r_act_blank[i] | w_lz_mask[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_glyph #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_glyph (
    .nibble (w_nib),
    .seg    (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= c_seg_off;
      r_seg_dp     <= c_dp_off;
      r_an         <= c_an_off;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_dark) begin
        r_seg    <= c_seg_off;
        r_seg_dp <= c_dp_off;
        r_an     <= c_an_off;
      end else begin
        r_seg    <= w_glyph;
        r_seg_dp <= SEG_ACTIVE_LOW ? ~w_dp_sel : w_dp_sel;
        r_an     <= DIG_ACTIVE_LOW ? ~w_onehot : w_onehot;
      end
    end
  end

  assign seg        = r_seg;
  assign seg_dp     = r_seg_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
